bias_relu_writeback: RTL and testbench

//  Downstream stage of the dot-product engine. Per produced neuron sum (signed Q16.16): fetch bias[i] from

---
 rtl/dnn_accel_pkg.sv | 34 +++
 rtl/bias_relu_writeback_if.sv | 43 ++++
 rtl/q16_bias_act.sv | 18 +
 rtl/bias_relu_writeback.sv | 128 ++++++++++++
 tb/tb_bias_relu_writeback.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_accel_pkg.sv
// Shared types for the DNN accelerator datapath: Q16.16 fixed point, register map,
// writeback FSM states and the saturating adder also used by the dot engine.
package dnn_accel_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] q16_16_t;

  localparam logic [3:0] REG_START     = 4'd0;
  localparam logic [3:0] REG_BIAS_BASE = 4'd1;
  localparam logic [3:0] REG_OUT_BASE  = 4'd2;
  localparam logic [3:0] REG_COUNT     = 4'd3;
  localparam logic [3:0] REG_CTRL      = 4'd4;
  localparam logic [3:0] REG_DONECNT   = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_RD_BIAS,
    ST_WAIT_BIAS,
    ST_COMPUTE,
    ST_WR_OUT
  } wb_state_t;

  // One guard bit is enough: disagreement between the top two bits means overflow.
  function automatic q16_16_t sat_add(input q16_16_t a, input q16_16_t b, input logic saturate);
    logic [DATA_W:0] wide;
    wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (saturate && (wide[DATA_W] != wide[DATA_W-1]))
      return wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return wide[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/bias_relu_writeback_if.sv
// Bus bundle of the bias/ReLU writeback stage: CPU register slave, dot-engine stream,
// SDRAM bias-read master and SRAM output-write master.
interface bias_relu_writeback_if;

  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;

  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  logic        master2_waitrequest;
  logic [31:0] master2_address;
  logic        master2_write;
  logic [31:0] master2_writedata;

  // The writeback block itself.
  modport slave (
    output slave_waitrequest, slave_readdata, in_ready,
           master_address, master_read, master2_address, master2_write, master2_writedata,
    input  slave_address, slave_read, slave_write, slave_writedata, in_valid, in_data,
           master_waitrequest, master_readdata, master_readdatavalid, master2_waitrequest
  );

  // CPU, dot engine and memories around it.
  modport master (
    input  slave_waitrequest, slave_readdata, in_ready,
           master_address, master_read, master2_address, master2_write, master2_writedata,
    output slave_address, slave_read, slave_write, slave_writedata, in_valid, in_data,
           master_waitrequest, master_readdata, master_readdatavalid, master2_waitrequest
  );

endinterface

// File: rtl/q16_bias_act.sv
// Combinational bias add (saturating or wrapping) followed by optional ReLU on Q16.16 values.
module q16_bias_act
  import dnn_accel_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  q16_16_t sum,
  input  q16_16_t bias,
  input  logic    relu_en,
  output q16_16_t result
);

  always_comb begin
    result = sat_add(sum, bias, SATURATE);
    if (relu_en && result[DATA_W-1]) result = '0;
  end

endmodule

// File: rtl/bias_relu_writeback.sv
// Per neuron sum: fetch bias from SDRAM, add, optional ReLU, write to SRAM at out_base+4*idx.
// CPU programs bases/count/ctrl, pulses start and polls busy/done_cnt.
module bias_relu_writeback
  import dnn_accel_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit SATURATE = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  bias_relu_writeback_if.slave bus
);

  wb_state_t         state, state_nxt;
  logic [31:0]       bias_base, out_base, count, done_cnt, idx;
  logic              relu_en;
  logic [DATA_W-1:0] sum_q, bias_q, result;
  logic              busy, start_acc, cfg_wr, idx_last;

  assign busy      = (state != ST_IDLE);
  assign cfg_wr    = bus.slave_write && !busy;
  assign start_acc = cfg_wr && (bus.slave_address == REG_START);
  assign idx_last  = (idx + 32'd1 == count);

  assign bus.slave_waitrequest = 1'b0;

  q16_bias_act #(.SATURATE(SATURATE)) u_act (
    .sum    (sum_q),
    .bias   (bias_q),
    .relu_en(relu_en),
    .result (result)
  );

  // NOTE: every registered signal uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: each output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt         = state;
    bus.in_ready      = 1'b0;
    bus.master_read   = 1'b0;
    bus.master2_write = 1'b0;
    case (state)
      ST_IDLE:      if (start_acc && count != 32'd0) state_nxt = ST_WAIT_IN;
      ST_WAIT_IN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ST_RD_BIAS;
      end
      ST_RD_BIAS: begin
        bus.master_read = 1'b1;
        // Zero-latency memories may return data in the very cycle the read is accepted.
        if (!bus.master_waitrequest)
          state_nxt = bus.master_readdatavalid ? ST_COMPUTE : ST_WAIT_BIAS;
      end
      ST_WAIT_BIAS: if (bus.master_readdatavalid) state_nxt = ST_COMPUTE;
      ST_COMPUTE:   state_nxt = ST_WR_OUT;
      ST_WR_OUT: begin
        bus.master2_write = 1'b1;
        if (!bus.master2_waitrequest) state_nxt = idx_last ? ST_IDLE : ST_WAIT_IN;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bias_base             <= '0;
      out_base              <= '0;
      count                 <= '0;
      relu_en               <= 1'b0;
      done_cnt              <= '0;
      idx                   <= '0;
      sum_q                 <= '0;
      bias_q                <= '0;
      bus.master_address    <= '0;
      bus.master2_address   <= '0;
      bus.master2_writedata <= '0;
    end else begin
      if (cfg_wr) begin
        case (bus.slave_address)
          REG_BIAS_BASE: bias_base <= bus.slave_writedata;
          REG_OUT_BASE:  out_base  <= bus.slave_writedata;
          REG_COUNT:     count     <= bus.slave_writedata;
          REG_CTRL:      relu_en   <= bus.slave_writedata[0];
          default: ;
        endcase
      end
      if (start_acc) begin
        done_cnt <= '0;
        idx      <= '0;
      end
      if (state == ST_WAIT_IN && bus.in_valid) begin
        sum_q              <= bus.in_data;
        bus.master_address <= bias_base + {idx[29:0], 2'b00};
      end
      if ((state == ST_WAIT_BIAS || (state == ST_RD_BIAS && !bus.master_waitrequest))
          && bus.master_readdatavalid)
        bias_q <= bus.master_readdata;
      if (state == ST_COMPUTE) begin
        bus.master2_writedata <= result;
        bus.master2_address   <= out_base + {idx[29:0], 2'b00};
      end
      if (state == ST_WR_OUT && !bus.master2_waitrequest) begin
        done_cnt <= done_cnt + 32'd1;
        idx      <= idx_last ? 32'd0 : idx + 32'd1;
      end
    end
  end

  always_comb begin
    bus.slave_readdata = '0;
    if (bus.slave_read) begin
      case (bus.slave_address)
        REG_START:     bus.slave_readdata = {31'b0, busy};
        REG_BIAS_BASE: bus.slave_readdata = bias_base;
        REG_OUT_BASE:  bus.slave_readdata = out_base;
        REG_COUNT:     bus.slave_readdata = count;
        REG_CTRL:      bus.slave_readdata = {31'b0, relu_en};
        REG_DONECNT:   bus.slave_readdata = done_cnt;
        default:       bus.slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu_writeback.sv
// Self-checking bench for bias_relu_writeback: bus models for CPU, stream, SDRAM and SRAM,
// results compared against a plain-arithmetic saturate/ReLU reference.
module tb_bias_relu_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_relu_writeback_if ifc();

  bias_relu_writeback #(.DATA_W(32), .SATURATE(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  bit          rand_mode = 1'b0;
  bit          hold_en   = 1'b0;
  logic [31:0] hold_addr = '0;

  logic [31:0] sdram [logic [31:0]];
  logic [31:0] sum_fifo[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] sums[$];
  logic [31:0] biases[$];

  int overlap_err = 0;
  int stable_err  = 0;
  int outst_err   = 0;
  int strobe_cnt  = 0;

  // Reference: exact signed sum, clamped to the 32-bit range, then ReLU.
  function automatic logic [31:0] ref_result(input logic [31:0] s, input logic [31:0] b, input bit relu);
    longint r;
    r = longint'($signed(s)) + longint'($signed(b));
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    if (relu && r < 0) r = 0;
    return r[31:0];
  endfunction

  // SDRAM and SRAM slaves plus protocol watchers; all driving happens on the falling edge.
  initial begin
    int          pend_cnt;
    int          dly;
    logic [31:0] pend_data, rd_val, p_ra, p_wa, p_wd;
    bit          rd_stall, wr_stall;
    pend_cnt = 0; pend_data = '0; rd_stall = 1'b0; wr_stall = 1'b0;
    p_ra = '0; p_wa = '0; p_wd = '0;
    ifc.master_waitrequest   = 1'b0;
    ifc.master_readdata      = '0;
    ifc.master_readdatavalid = 1'b0;
    ifc.master2_waitrequest  = 1'b0;
    forever begin
      @(negedge clk);
      ifc.master_readdatavalid = 1'b0;
      ifc.master_readdata      = $urandom();
      if (!rst_n) begin
        pend_cnt = 0; rd_stall = 1'b0; wr_stall = 1'b0;
      end else begin
        if (ifc.master_read && ifc.master2_write) overlap_err++;
        if (ifc.master_read || ifc.master2_write) strobe_cnt++;
        if (rd_stall && (!ifc.master_read || ifc.master_address !== p_ra)) stable_err++;
        if (wr_stall && (!ifc.master2_write || ifc.master2_address !== p_wa ||
                         ifc.master2_writedata !== p_wd)) stable_err++;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            ifc.master_readdatavalid = 1'b1;
            ifc.master_readdata      = pend_data;
          end
        end
        ifc.master_waitrequest  = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
        ifc.master2_waitrequest = (hold_en && ifc.master2_address == hold_addr) ? 1'b1 :
                                  rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
        rd_stall = ifc.master_read && ifc.master_waitrequest;
        wr_stall = ifc.master2_write && ifc.master2_waitrequest;
        p_ra = ifc.master_address; p_wa = ifc.master2_address; p_wd = ifc.master2_writedata;
        if (ifc.master_read && !ifc.master_waitrequest) begin
          if (pend_cnt > 0) outst_err++;
          rd_val = sdram.exists(ifc.master_address) ? sdram[ifc.master_address] : 32'hDEAD_BEEF;
          dly = rand_mode ? $urandom_range(0, 4) : 0;
          if (dly == 0) begin
            ifc.master_readdatavalid = 1'b1;
            ifc.master_readdata      = rd_val;
          end else begin
            pend_cnt  = dly;
            pend_data = rd_val;
          end
        end
        if (ifc.master2_write && !ifc.master2_waitrequest) begin
          wr_addr.push_back(ifc.master2_address);
          wr_data.push_back(ifc.master2_writedata);
        end
      end
    end
  end

  // Dot-engine stand-in: offers queued sums, pops one per accepted handshake.
  initial begin
    bit take;
    take = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    forever begin
      @(negedge clk);
      if (take && sum_fifo.size() > 0) void'(sum_fifo.pop_front());
      if (sum_fifo.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        ifc.in_valid = 1'b1;
        ifc.in_data  = sum_fifo[0];
      end else begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = $urandom();
      end
      take = ifc.in_valid && ifc.in_ready && rst_n;
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ifc.slave_address = a; ifc.slave_writedata = d; ifc.slave_write = 1'b1;
    @(negedge clk);
    ifc.slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    ifc.slave_address = a; ifc.slave_read = 1'b1;
    #1 d = ifc.slave_readdata;
    ifc.slave_read = 1'b0;
  endtask

  // Programs one layer from sums/biases, starts it and polls busy with a bounded budget.
  task automatic run_layer(input logic [31:0] bb, input logic [31:0] ob, input int cnt,
                           input bit relu, input bit poke, output bit timed_out);
    logic [31:0] r;
    for (int i = 0; i < cnt; i++) sdram[bb + 32'(4 * i)] = biases[i];
    sum_fifo = sums;
    wr_addr.delete();
    wr_data.delete();
    cpu_write(4'd1, bb);
    cpu_write(4'd2, ob);
    cpu_write(4'd3, 32'(cnt));
    cpu_write(4'd4, {31'b0, relu});
    cpu_write(4'd0, 32'h0);
    if (poke) begin
      cpu_write(4'd3, 32'(cnt + 5));
      cpu_write(4'd0, 32'h0);
    end
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cpu_read(4'd0, r);
      if (r[0] == 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      cpu_read(4'(a), r);
      check_cnt++;
      if (r !== 32'h0) $display("FAIL reset_reg%0d got %h want 00000000", a, r);
      else pass_cnt++;
    end
    check_cnt++;
    if ({ifc.in_ready, ifc.master_read, ifc.master2_write} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {ifc.in_ready, ifc.master_read, ifc.master2_write});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit to; logic [31:0] exp, r;
    sums   = '{32'h0002_0000, 32'h0000_8000, 32'hFFFF_8000};
    biases = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000};
    run_layer(32'h1000_0000, 32'h2000_0000, 3, 1'b0, 1'b0, to);
    check_cnt++;
    if (to) $display("FAIL basic_timeout got busy stuck want idle"); else pass_cnt++;
    check_cnt++;
    if (wr_data.size() != 3) $display("FAIL basic_wr_count got %0d want 3", wr_data.size());
    else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 3; i++) begin
      exp = ref_result(sums[i], biases[i], 1'b0);
      check_cnt++;
      if (wr_addr[i] !== 32'h2000_0000 + 32'(4 * i) || wr_data[i] !== exp)
        $display("FAIL basic[%0d] got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], exp, 32'h2000_0000 + 32'(4 * i));
      else pass_cnt++;
    end
    cpu_read(4'd5, r);
    check_cnt++;
    if (r !== 32'd3) $display("FAIL basic_done_cnt got %0d want 3", r); else pass_cnt++;
    cpu_read(4'd1, r);
    check_cnt++;
    if (r !== 32'h1000_0000) $display("FAIL basic_bias_base got %h want 10000000", r); else pass_cnt++;
    cpu_write(4'd9, 32'hFFFF_FFFF);
    cpu_read(4'd9, r);
    check_cnt++;
    if (r !== 32'h0) $display("FAIL unmapped_read got %h want 00000000", r); else pass_cnt++;
  endtask

  task automatic test_relu();
    bit to; logic [31:0] exp, r;
    run_layer(32'h1000_0000, 32'h2000_0100, 3, 1'b1, 1'b1, to);
    check_cnt++;
    if (to || wr_data.size() != 3) $display("FAIL relu_run got %0d writes (timeout %0d) want 3", wr_data.size(), to);
    else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 3; i++) begin
      exp = ref_result(sums[i], biases[i], 1'b1);
      check_cnt++;
      if (wr_addr[i] !== 32'h2000_0100 + 32'(4 * i) || wr_data[i] !== exp)
        $display("FAIL relu[%0d] got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], exp, 32'h2000_0100 + 32'(4 * i));
      else pass_cnt++;
    end
    cpu_read(4'd3, r);
    check_cnt++;
    if (r !== 32'd3) $display("FAIL busy_cfg_write got count %0d want 3", r); else pass_cnt++;
    cpu_read(4'd5, r);
    check_cnt++;
    if (r !== 32'd3) $display("FAIL busy_restart got done_cnt %0d want 3", r); else pass_cnt++;
  endtask

  task automatic test_saturation();
    bit to; logic [31:0] exp;
    sums   = '{32'h7FFF_0000, 32'h8000_0000, 32'h4000_0000};
    biases = '{32'h0002_0000, 32'hFFFF_0000, 32'hC000_0000};
    run_layer(32'h0000_4000, 32'h0000_8000, 3, 1'b0, 1'b0, to);
    check_cnt++;
    if (to || wr_data.size() != 3) $display("FAIL sat_run got %0d writes (timeout %0d) want 3", wr_data.size(), to);
    else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 3; i++) begin
      exp = ref_result(sums[i], biases[i], 1'b0);
      check_cnt++;
      if (wr_data[i] !== exp) $display("FAIL sat[%0d] got %h want %h", i, wr_data[i], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_count_zero();
    bit to; logic [31:0] r; int strobes;
    strobes = strobe_cnt;
    sums.delete(); biases.delete();
    run_layer(32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, to);
    repeat (10) @(negedge clk);
    check_cnt++;
    if (to) $display("FAIL zero_busy got busy=1 want 0"); else pass_cnt++;
    check_cnt++;
    if (strobe_cnt != strobes || wr_data.size() != 0)
      $display("FAIL zero_traffic got %0d strobe cycles want 0", strobe_cnt - strobes);
    else pass_cnt++;
    cpu_read(4'd5, r);
    check_cnt++;
    if (r !== 32'd0) $display("FAIL zero_done_cnt got %0d want 0", r); else pass_cnt++;
  endtask

  task automatic test_random_wait();
    bit to; logic [31:0] exp, ob;
    int n;
    n = 8;
    sums.delete(); biases.delete();
    for (int i = 0; i < n; i++) begin
      sums.push_back(($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 3'b111, 28'($urandom())} : $urandom());
      biases.push_back($urandom());
    end
    ob = $urandom() & 32'hFFFF_FFFC;
    rand_mode = 1'b1;
    run_layer(32'hFFFF_FFF0, ob, n, 1'($urandom_range(0, 1)), 1'b0, to);
    rand_mode = 1'b0;
    check_cnt++;
    if (to || wr_data.size() != n) $display("FAIL rand_run got %0d writes (timeout %0d) want %0d", wr_data.size(), to, n);
    else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < n; i++) begin
      exp = ref_result(sums[i], biases[i], dut.relu_en);
      check_cnt++;
      if (wr_addr[i] !== ob + 32'(4 * i) || wr_data[i] !== exp)
        $display("FAIL rand[%0d] got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], exp, ob + 32'(4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_write();
    bit to, seen; logic [31:0] r, exp;
    sums   = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    biases = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    hold_en = 1'b1; hold_addr = 32'h3000_0004;
    sum_fifo = sums;
    for (int i = 0; i < 3; i++) sdram[32'h5000_0000 + 32'(4 * i)] = biases[i];
    cpu_write(4'd1, 32'h5000_0000);
    cpu_write(4'd2, 32'h3000_0000);
    cpu_write(4'd3, 32'd3);
    cpu_write(4'd4, 32'd0);
    cpu_write(4'd0, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = ifc.master2_write && ifc.master2_address == hold_addr;
    end
    check_cnt++;
    if (!seen) $display("FAIL rst_mid_reach got no write to %h want one", hold_addr); else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_cnt++;
    if ({ifc.master_read, ifc.master2_write, ifc.in_ready} !== 3'b000)
      $display("FAIL rst_mid_strobes got %b want 000", {ifc.master_read, ifc.master2_write, ifc.in_ready});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    hold_en = 1'b0;
    sum_fifo.delete();
    for (int a = 0; a < 6; a++) begin
      cpu_read(4'(a), r);
      check_cnt++;
      if (r !== 32'h0) $display("FAIL rst_mid_reg%0d got %h want 00000000", a, r); else pass_cnt++;
    end
    sums   = '{32'hFFF0_0000, 32'h0000_0001};
    biases = '{32'h0001_0000, 32'h7FFF_FFFF};
    run_layer(32'h5000_0100, 32'h3000_0040, 2, 1'b0, 1'b0, to);
    check_cnt++;
    if (to || wr_data.size() != 2) $display("FAIL rst_fresh_run got %0d writes (timeout %0d) want 2", wr_data.size(), to);
    else pass_cnt++;
    for (int i = 0; i < wr_data.size() && i < 2; i++) begin
      exp = ref_result(sums[i], biases[i], 1'b0);
      check_cnt++;
      if (wr_addr[i] !== 32'h3000_0040 + 32'(4 * i) || wr_data[i] !== exp)
        $display("FAIL rst_fresh[%0d] got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], exp, 32'h3000_0040 + 32'(4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_bus_rules();
    check_cnt++;
    if (overlap_err != 0) $display("FAIL bus_overlap got %0d cycles want 0", overlap_err); else pass_cnt++;
    check_cnt++;
    if (stable_err != 0) $display("FAIL bus_stable got %0d violations want 0", stable_err); else pass_cnt++;
    check_cnt++;
    if (outst_err != 0) $display("FAIL bus_outstanding got %0d extra reads want 0", outst_err); else pass_cnt++;
  endtask

  initial begin
    ifc.slave_address   = '0;
    ifc.slave_read      = 1'b0;
    ifc.slave_write     = 1'b0;
    ifc.slave_writedata = '0;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_count_zero();
    test_random_wait();
    test_random_wait();
    test_reset_mid_write();
    test_bus_rules();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
